// File: rtl/pet_pkg.sv
// Shared state codes and helpers for the virtual-pet need controller.
package pet_pkg;

   localparam int STATE_W = 4;

   typedef enum logic [STATE_W-1:0] {
      IDLE    = 4'd0,
      ALERT   = 4'd1,
      ENGAGED = 4'd2,
      SERVING = 4'd3,
      DEAD    = 4'd4
   } state_t;

   // Index of the lowest set bit; 0 when the vector is empty.
   function automatic logic [2:0] lowest_set(input logic [7:0] v);
      lowest_set = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (v[i]) lowest_set = 3'(i);
      end
   endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running prescaler: sec_tick is a registered one-cycle pulse every CLK_HZ cycles.
module tick_gen #(
   parameter int CLK_HZ = 50000000
) (
   input  logic clk,
   input  logic reset,
   output logic sec_tick
);

   localparam int CW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLK_HZ - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt      <= '0;
         sec_tick <= 1'b0;
      end else if (cnt == LAST) begin
         cnt      <= '0;
         sec_tick <= 1'b1;
      end else begin
         cnt      <= cnt + 1'b1;
         sec_tick <= 1'b0;
      end
   end

endmodule

// File: rtl/pet_need_ctrl.sv
// Need timers, alert/engage/serve state machine and health score for the virtual pet.
// dist_valid is a one-cycle strobe with no back-pressure: a reading is taken only while meas_stop is low.
module pet_need_ctrl
   import pet_pkg::*;
#(
   parameter int CLK_HZ      = 50000000,
   parameter int N_NEEDS     = 3,
   parameter int TIMER_W     = 12,
   parameter logic [N_NEEDS*TIMER_W-1:0] TIMEOUT_S = {12'd120, 12'd90, 12'd60},
   parameter int DIST_W      = 16,
   parameter int PROX_CM     = 5,
   parameter int ENGAGE_TO_S = 10,
   parameter int SERVE_S     = 3,
   parameter int HEALTH_MAX  = 255,
   parameter int HEAL        = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               prox_en,
   input  logic [DIST_W-1:0]  dist_cm,
   input  logic               dist_valid,
   input  logic [N_NEEDS-1:0] act,
   output logic [3:0]         state,
   output logic [2:0]         need_idx,
   output logic [N_NEEDS-1:0] pending,
   output logic [7:0]         health,
   output logic [TIMER_W-1:0] seconds,
   output logic               meas_stop,
   output logic               sec_tick
);

   localparam int ETW = $clog2(ENGAGE_TO_S + 1);
   localparam int STW = $clog2(SERVE_S + 1);

   state_t state_q, state_d;

   logic [TIMER_W-1:0] need_cnt [N_NEEDS];
   logic [N_NEEDS-1:0] act_s1, act_s2, act_q, act_rise, idx_hot;
   logic [ETW-1:0]     eng_t;
   logic [STW-1:0]     srv_t;
   logic               near, sel_rise;
   logic               eng_timeout, serve_done;
   logic               dec_health, engage_start, serve_start, enter_alert, freeze_sel, cnt_run;
   logic [8:0]         health_sum;
   logic [7:0]         health_sat;

   tick_gen #(.CLK_HZ(CLK_HZ)) u_tick (
      .clk      (clk),
      .reset    (reset),
      .sec_tick (sec_tick)
   );

   assign state       = state_q;
   assign act_rise    = act_s2 & ~act_q;
   assign sel_rise    = |(act_rise & idx_hot);
   assign eng_timeout = (state_q == ENGAGED) && sec_tick && (eng_t == ETW'(ENGAGE_TO_S - 1));
   assign serve_done  = (state_q == SERVING) && sec_tick && (srv_t == STW'(SERVE_S - 1));
   assign health_sum  = {1'b0, health} + 9'(HEAL);
   assign health_sat  = (health_sum > 9'(HEALTH_MAX)) ? 8'(HEALTH_MAX) : health_sum[7:0];

   always_comb begin
      idx_hot = '0;
      seconds = '0;
      for (int i = 0; i < N_NEEDS; i++) begin
         if (need_idx == 3'(i)) begin
            idx_hot[i] = 1'b1;
            seconds    = need_cnt[i];
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // A correct button press beats a simultaneous engage timeout; death beats engaging.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (|pending) state_d = ALERT;
         ALERT:   begin
            if (sec_tick && (health <= 8'd1)) state_d = DEAD;
            else if (near)                    state_d = ENGAGED;
         end
         ENGAGED: begin
            if (sel_rise)         state_d = SERVING;
            else if (eng_timeout) state_d = ALERT;
         end
         SERVING: if (serve_done) state_d = IDLE;
         DEAD:    state_d = DEAD;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      dec_health   = (state_q == ALERT) && sec_tick;
      engage_start = (state_q == ALERT) && (state_d == ENGAGED);
      serve_start  = (state_q == ENGAGED) && (state_d == SERVING);
      enter_alert  = (state_q != ALERT) && (state_d == ALERT);
      freeze_sel   = (state_q == ENGAGED) || (state_q == SERVING);
      cnt_run      = sec_tick && (state_q != DEAD);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         act_s1    <= '0;
         act_s2    <= '0;
         act_q     <= '0;
         need_idx  <= '0;
         pending   <= '0;
         health    <= 8'(HEALTH_MAX);
         meas_stop <= 1'b0;
         near      <= 1'b0;
         eng_t     <= '0;
         srv_t     <= '0;
         for (int i = 0; i < N_NEEDS; i++) need_cnt[i] <= '0;
      end else begin
         act_s1    <= act;
         act_s2    <= act_s1;
         act_q     <= act_s2;
         meas_stop <= (state_d == ENGAGED) || (state_d == SERVING);

         if ((state_q == IDLE) && (|pending)) need_idx <= lowest_set(8'(pending));

         if (dec_health)      health <= health - 8'd1;
         else if (serve_done) health <= health_sat;

         if (enter_alert)                   near <= 1'b0;
         else if (dist_valid && !meas_stop) near <= prox_en && (dist_cm <= DIST_W'(PROX_CM));

         if (engage_start)                          eng_t <= '0;
         else if ((state_q == ENGAGED) && sec_tick) eng_t <= eng_t + 1'b1;

         if (serve_start)                           srv_t <= '0;
         else if ((state_q == SERVING) && sec_tick) srv_t <= srv_t + 1'b1;

         // Clearing the served need overrides a timeout landing on the same tick.
         for (int i = 0; i < N_NEEDS; i++) begin
            if (serve_done && idx_hot[i]) begin
               need_cnt[i] <= '0;
               pending[i]  <= 1'b0;
            end else if (cnt_run && !(freeze_sel && idx_hot[i]) &&
                         (need_cnt[i] < TIMEOUT_S[i*TIMER_W +: TIMER_W])) begin
               need_cnt[i] <= need_cnt[i] + 1'b1;
               if (need_cnt[i] + 1'b1 == TIMEOUT_S[i*TIMER_W +: TIMER_W]) pending[i] <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_pet_need_ctrl.sv
// Randomised bench for pet_need_ctrl: a behavioural pet model predicts every output change.
module tb_pet_need_ctrl;

   localparam logic [27:0] RESET_OBS = {4'd0, 3'd0, 3'd0, 8'd255, 1'b0, 8'd0, 1'b0};

   logic        clk = 1'b0;
   logic        reset;
   logic        prox_en;
   logic [15:0] dist_cm;
   logic        dist_valid;
   logic [2:0]  act;
   logic [3:0]  state;
   logic [2:0]  need_idx;
   logic [2:0]  pending;
   logic [7:0]  health;
   logic [7:0]  seconds;
   logic        meas_stop;
   logic        sec_tick;

   pet_need_ctrl #(
      .CLK_HZ      (10),
      .N_NEEDS     (3),
      .TIMER_W     (8),
      .TIMEOUT_S   (24'h090604),
      .DIST_W      (16),
      .PROX_CM     (5),
      .ENGAGE_TO_S (3),
      .SERVE_S     (2),
      .HEALTH_MAX  (255),
      .HEAL        (32)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .prox_en    (prox_en),
      .dist_cm    (dist_cm),
      .dist_valid (dist_valid),
      .act        (act),
      .state      (state),
      .need_idx   (need_idx),
      .pending    (pending),
      .health     (health),
      .seconds    (seconds),
      .meas_stop  (meas_stop),
      .sec_tick   (sec_tick)
   );

   // ---------------- clock / watchdog ----------------
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   logic [47:0] exp_q[$];
   int          ncyc = 0;
   int          to_s [3] = '{4, 6, 9};
   int          m_state, m_idx, m_health, m_ticks, m_edges;
   int          m_cnt [3];
   bit [2:0]    m_pend, h1, h2, h3;
   bit          m_ms, m_near, m_tick;
   logic [27:0] last_obs = RESET_OBS;

   task automatic model_reset();
      m_state = 0; m_idx = 0; m_health = 255; m_ticks = 0; m_edges = 0;
      m_pend = '0; m_ms = 0; m_near = 0; m_tick = 0;
      h1 = '0; h2 = '0; h3 = '0;
      for (int i = 0; i < 3; i++) m_cnt[i] = 0;
   endtask

   function automatic logic [27:0] m_obs();
      return {4'(m_state), 3'(m_idx), m_pend, 8'(m_health), m_ms, 8'(m_cnt[m_idx]), m_tick};
   endfunction

   task automatic model_step();
      bit       tick, done, nn;
      bit [2:0] rise, np;
      int       ns, nidx, nh, nt;
      int       nc [3];
      tick = m_tick;
      rise = h2 & ~h3;
      ns = m_state; nidx = m_idx; nh = m_health; nt = m_ticks; done = 0;
      case (m_state)
         0: if (m_pend != 0) begin
            ns = 1;
            for (int i = 2; i >= 0; i--) if (m_pend[i]) nidx = i;
         end
         1: begin
            if (tick) nh = m_health - 1;
            if (tick && nh == 0) ns = 4;
            else if (m_near) begin ns = 2; nt = 0; end
         end
         2: if (rise[m_idx]) begin
            ns = 3; nt = 0;
         end else if (tick) begin
            nt = m_ticks + 1;
            if (nt == 3) ns = 1;
         end
         3: if (tick) begin
            nt = m_ticks + 1;
            if (nt == 2) begin
               done = 1; ns = 0;
               nh = (m_health + 32 > 255) ? 255 : m_health + 32;
            end
         end
         default: ;
      endcase
      for (int i = 0; i < 3; i++) begin
         np[i] = m_pend[i];
         nc[i] = m_cnt[i];
         if (done && i == m_idx) begin
            nc[i] = 0; np[i] = 0;
         end else if (tick && m_state != 4 && !(i == m_idx && (m_state == 2 || m_state == 3))
                      && m_cnt[i] < to_s[i]) begin
            nc[i] = m_cnt[i] + 1;
            if (nc[i] == to_s[i]) np[i] = 1;
         end
      end
      if (ns == 1 && m_state != 1)       nn = 0;
      else if (dist_valid && !m_ms)      nn = prox_en && (dist_cm <= 16'd5);
      else                               nn = m_near;
      m_state = ns; m_idx = nidx; m_health = nh; m_ticks = nt; m_pend = np; m_near = nn;
      for (int i = 0; i < 3; i++) m_cnt[i] = nc[i];
      m_ms = (ns == 2 || ns == 3);
      h3 = h2; h2 = h1; h1 = act;
      m_edges++;
      m_tick = (m_edges % 10 == 0);
   endtask

   always @(posedge clk or posedge reset) begin
      if (reset) model_reset();
      else       model_step();
      if (m_obs() != last_obs) begin
         last_obs = m_obs();
         exp_q.push_back({ncyc[19:0], last_obs});
      end
   end

   // ---------------- monitor / scoreboard ----------------
   int          tests = 0;
   int          fails = 0;
   int          wait_miss = 0;
   int          wait_seen = 0;
   bit          done = 0;
   logic [27:0] prev_obs = RESET_OBS;
   logic [27:0] obs;
   logic [47:0] e;

   always @(negedge clk) begin
      obs = {state, need_idx, pending, health, meas_stop, seconds, sec_tick};
      if (ncyc == 0) begin
         tests++;
         if (obs !== RESET_OBS) begin
            fails++;
            $display("FAIL reset_state got=%h exp=%h", obs, RESET_OBS);
         end
      end
      if (obs !== prev_obs) begin
         prev_obs = obs;
         tests++;
         if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_change cyc=%0d got=%h (no change predicted)", ncyc, obs);
         end else begin
            e = exp_q.pop_front();
            if (e !== {ncyc[19:0], obs}) begin
               fails++;
               $display("FAIL out_event [cyc|state|idx|pend|health|ms|sec|tick] got=%0d|%0d|%0d|%b|%0d|%b|%0d|%b exp=%0d|%0d|%0d|%b|%0d|%b|%0d|%b",
                        ncyc, state, need_idx, pending, health, meas_stop, seconds, sec_tick,
                        e[47:28], e[27:24], e[23:21], e[20:18], e[17:10], e[9], e[8:1], e[0]);
            end
         end
      end
      if (wait_miss != wait_seen) begin
         tests += wait_miss - wait_seen;
         fails += wait_miss - wait_seen;
         wait_seen = wait_miss;
      end
      if (done) begin
         tests++;
         if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain got=%0d pending predictions required=0", exp_q.size());
         end
         $display("[TB] %0d tests run, %0d failed", tests, fails);
         $finish;
      end
      ncyc++;
   end

   // ---------------- driver tasks ----------------
   task automatic step(input int n);
      repeat (n) begin
         @(negedge clk);
         dist_valid = 1'b0;
         if ($urandom_range(0, 5) == 0) begin
            dist_valid = 1'b1;
            dist_cm    = 16'($urandom_range(6, 300));
            prox_en    = 1'($urandom_range(0, 1));
         end
      end
   endtask

   task automatic send_near();
      @(negedge clk);
      dist_valid = 1'b1;
      dist_cm    = 16'($urandom_range(0, 5));
      prox_en    = 1'b1;
      @(negedge clk);
      dist_valid = 1'b0;
   endtask

   task automatic press(input logic [2:0] bits, input int hold);
      @(negedge clk);
      act = bits;
      repeat (hold) @(negedge clk);
      act = 3'b000;
   endtask

   task automatic wait_state(input logic [3:0] s, input int budget);
      int n = 0;
      while (state !== s && n < budget) begin
         @(negedge clk);
         dist_valid = 1'b0;
         n++;
      end
      if (state !== s) begin
         wait_miss++;
         $display("FAIL wait_state got=%0d required=%0d after %0d cycles", state, s, n);
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [2:0] right, wrong;
      int choice;
      reset = 1'b1; act = '0; dist_valid = 1'b0; dist_cm = '0; prox_en = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;

      // first timeout: need 0 at tick 4
      wait_state(4'd1, 100);

      // far or disabled readings must not engage
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         dist_valid = 1'b1;
         if (k % 2 == 1) begin dist_cm = 16'($urandom_range(6, 300)); prox_en = 1'b1; end
         else            begin dist_cm = 16'($urandom_range(0, 5));   prox_en = 1'b0; end
         step(2);
      end
      send_near();
      wait_state(4'd2, 5);

      // wrong button ignored, right one serves
      press(3'b010, 2);
      step(2);
      press(3'b001, 4);
      wait_state(4'd3, 8);
      wait_state(4'd0, 40);

      // engage with no action -> back to ALERT
      wait_state(4'd1, 300);
      send_near();
      wait_state(4'd2, 5);
      wait_state(4'd1, 60);

      // randomised engage / serve rounds
      for (int r = 0; r < 10; r++) begin
         wait_state(4'd1, 300);
         step($urandom_range(0, 25));
         send_near();
         wait_state(4'd2, 5);
         right  = 3'(1 << need_idx);
         wrong  = 3'(1 << ((need_idx + 1) % 3));
         choice = $urandom_range(0, 3);
         case (choice)
            0: wait_state(4'd1, 60);
            1: begin
               press(wrong, 2);
               step($urandom_range(0, 6));
               press(right, $urandom_range(1, 4));
               wait_state(4'd3, 10);
            end
            2: begin
               step($urandom_range(0, 12));
               press(right, $urandom_range(1, 4));
               wait_state(4'd3, 10);
            end
            default: begin
               press(wrong, 3);
               wait_state(4'd1, 60);
            end
         endcase
      end

      // asynchronous reset in the middle of a serve
      wait_state(4'd1, 300);
      send_near();
      wait_state(4'd2, 5);
      press(3'(1 << need_idx), 3);
      wait_state(4'd3, 10);
      step(5);
      @(negedge clk);
      #2 reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;

      // starve the pet until it dies, then confirm everything stays frozen
      wait_state(4'd1, 200);
      wait_state(4'd4, 3000);
      step(40);
      done = 1'b1;
   end

endmodule
